// File: rtl/pic_irq_core.sv
// rtl/pic_irq_core.sv - Interrupt core: IMR/IRR/ISR, edge/level detect, nested/rotating priority.
module pic_irq_core #(
  parameter  int N_IRQ = 8,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ltim,
  input  logic             imr_wr,
  input  logic [N_IRQ-1:0] data,
  input  logic             rotate,
  input  logic             eoi,
  input  logic             inta,
  output logic             int_req,
  output logic [ID_W-1:0]  vec,
  output logic [N_IRQ-1:0] imr,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr
);

  localparam logic [ID_W-1:0] LP_RESET = ID_W'(N_IRQ - 1);

  logic [N_IRQ-1:0] imr_q, imr_d;
  logic [N_IRQ-1:0] irr_q, irr_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic             int_q, int_d;
  logic [ID_W-1:0]  w_q, w_d;
  logic [ID_W-1:0]  vec_q, vec_d;
  logic [ID_W-1:0]  lp_q, lp_d;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] cand_v;
  logic [N_IRQ-1:0] grant_mask;
  logic [N_IRQ-1:0] eoi_mask;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  isr_top;
  logic             qual;
  logic             grant;
  logic             eoi_hit;

  // Scan starts just above the lowest-priority line and wraps.
  function automatic logic [ID_W-1:0] pick(input logic [N_IRQ-1:0] v,
                                           input logic [ID_W-1:0]  lp);
    logic [ID_W-1:0] r;
    logic [ID_W-1:0] sel;
    logic            hit;
    int              idx;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = int'(lp) + 1 + k;
      if (idx >= N_IRQ) idx = idx - N_IRQ;
      sel = ID_W'(idx);
      if (!hit && v[sel]) begin
        hit = 1'b1;
        r   = sel;
      end
    end
    return r;
  endfunction

  // Rank 0 is the highest priority under the current lowest-priority pointer.
  function automatic int rank(input logic [ID_W-1:0] idx, input logic [ID_W-1:0] lp);
    if (int'(idx) > int'(lp)) return int'(idx) - int'(lp) - 1;
    return int'(idx) + N_IRQ - 1 - int'(lp);
  endfunction

  always_comb begin
    edge_det   = irq & ~irq_q;
    cand_v     = irr_q & ~imr_q;
    cand       = pick(cand_v, lp_q);
    isr_top    = pick(isr_q, lp_q);
    qual       = (|cand_v) && ((isr_q == '0) || (rank(cand, lp_q) < rank(isr_top, lp_q)));
    grant      = inta & int_q;
    grant_mask = grant ? (N_IRQ'(1) << w_q) : '0;
    eoi_hit    = eoi & (|isr_q);
    eoi_mask   = eoi_hit ? (N_IRQ'(1) << isr_top) : '0;

    irq_d = irq;
    irr_d = ltim ? (irq & ~grant_mask) : ((irr_q & ~grant_mask) | edge_det);
    // EOI works on the pre-cycle ISR; a simultaneous grant bit is then OR-ed in.
    isr_d = (isr_q & ~eoi_mask) | grant_mask;
    lp_d  = (eoi_hit && rotate) ? isr_top : lp_q;
    imr_d = imr_wr ? data : imr_q;
    vec_d = grant ? w_q : vec_q;
    // A grant forces one idle cycle so the same line cannot be acknowledged twice.
    int_d = qual & ~grant;
    w_d   = cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imr_q <= '0;
      irr_q <= '0;
      isr_q <= '0;
      irq_q <= '0;
      int_q <= 1'b0;
      w_q   <= '0;
      vec_q <= '0;
      lp_q  <= LP_RESET;
    end else begin
      imr_q <= imr_d;
      irr_q <= irr_d;
      isr_q <= isr_d;
      irq_q <= irq_d;
      int_q <= int_d;
      w_q   <= w_d;
      vec_q <= vec_d;
      lp_q  <= lp_d;
    end
  end

  assign int_req = int_q;
  assign vec     = vec_q;
  assign imr     = imr_q;
  assign irr     = irr_q;
  assign isr     = isr_q;

endmodule

// File: tb/tb_pic_irq_core.sv
// tb/tb_pic_irq_core.sv - Directed self-checking bench for pic_irq_core.
module tb_pic_irq_core;

  localparam int N_IRQ = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_IRQ-1:0] irq = '0;
  logic             ltim = 1'b0;
  logic             imr_wr = 1'b0;
  logic [N_IRQ-1:0] data = '0;
  logic             rotate = 1'b0;
  logic             eoi = 1'b0;
  logic             inta = 1'b0;
  logic             int_req;
  logic [ID_W-1:0]  vec;
  logic [N_IRQ-1:0] imr;
  logic [N_IRQ-1:0] irr;
  logic [N_IRQ-1:0] isr;

  int total  = 0;
  int passed = 0;

  pic_irq_core #(.N_IRQ(N_IRQ)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .ltim(ltim), .imr_wr(imr_wr),
    .data(data), .rotate(rotate), .eoi(eoi), .inta(inta), .int_req(int_req),
    .vec(vec), .imr(imr), .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inta();
    inta = 1'b1; tick(); inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic do_reset();
    irq = '0; ltim = 1'b0; imr_wr = 1'b0; data = '0; rotate = 1'b0; eoi = 1'b0; inta = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({int_req, vec, imr, irr, isr} !== '0) $display("FAIL reset_state got int=%0b vec=%0d imr=%h irr=%h isr=%h want all 0", int_req, vec, imr, irr, isr); else passed++;
  endtask

  task automatic test_edge_grant();
    do_reset();
    irq = 8'h08; tick();
    total++; if (irr !== 8'h08) $display("FAIL edge_irr got %h want 08", irr); else passed++;
    total++; if (int_req !== 1'b0) $display("FAIL edge_int_t1 got %0b want 0", int_req); else passed++;
    tick();
    total++; if (int_req !== 1'b1) $display("FAIL edge_int_t2 got %0b want 1", int_req); else passed++;
    pulse_inta();
    total++; if (isr !== 8'h08) $display("FAIL edge_isr got %h want 08", isr); else passed++;
    total++; if (irr !== 8'h00) $display("FAIL edge_irr_clr got %h want 00", irr); else passed++;
    total++; if (vec !== 3'd3) $display("FAIL edge_vec got %0d want 3", vec); else passed++;
    total++; if (int_req !== 1'b0) $display("FAIL edge_int_drop got %0b want 0", int_req); else passed++;
    tick();
    total++; if (int_req !== 1'b0) $display("FAIL edge_int_idle got %0b want 0", int_req); else passed++;
  endtask

  task automatic test_nested();
    do_reset();
    irq = 8'h84; tick();
    total++; if (irr !== 8'h84) $display("FAIL nest_irr got %h want 84", irr); else passed++;
    tick();
    pulse_inta();
    total++; if (vec !== 3'd2 || isr !== 8'h04 || irr !== 8'h80) $display("FAIL nest_grant2 got vec=%0d isr=%h irr=%h want 2 04 80", vec, isr, irr); else passed++;
    tick();
    total++; if (int_req !== 1'b0) $display("FAIL nest_blocked got %0b want 0", int_req); else passed++;
    pulse_eoi();
    total++; if (isr !== 8'h00) $display("FAIL nest_eoi got %h want 00", isr); else passed++;
    tick();
    total++; if (int_req !== 1'b1) $display("FAIL nest_int7 got %0b want 1", int_req); else passed++;
    pulse_inta();
    total++; if (vec !== 3'd7 || isr !== 8'h80) $display("FAIL nest_grant7 got vec=%0d isr=%h want 7 80", vec, isr); else passed++;
  endtask

  task automatic test_mask();
    do_reset();
    imr_wr = 1'b1; data = 8'h08; tick(); imr_wr = 1'b0;
    total++; if (imr !== 8'h08) $display("FAIL mask_imr got %h want 08", imr); else passed++;
    irq = 8'h08; tick(); tick(); tick();
    total++; if (irr !== 8'h08 || int_req !== 1'b0) $display("FAIL mask_hold got irr=%h int=%0b want 08 0", irr, int_req); else passed++;
    imr_wr = 1'b1; data = 8'h00; tick(); imr_wr = 1'b0;
    total++; if (int_req !== 1'b0) $display("FAIL mask_wr_cycle got %0b want 0", int_req); else passed++;
    tick();
    total++; if (int_req !== 1'b1) $display("FAIL mask_unmask got %0b want 1", int_req); else passed++;
  endtask

  task automatic test_rotate();
    do_reset();
    rotate = 1'b1;
    irq = 8'h01; tick(); tick();
    pulse_inta();
    total++; if (vec !== 3'd0 || isr !== 8'h01) $display("FAIL rot_grant0 got vec=%0d isr=%h want 0 01", vec, isr); else passed++;
    pulse_eoi();
    irq = 8'h00; tick();
    irq = 8'h21; tick();
    total++; if (irr !== 8'h21) $display("FAIL rot_irr got %h want 21", irr); else passed++;
    tick();
    pulse_inta();
    total++; if (vec !== 3'd5 || isr !== 8'h20) $display("FAIL rot_grant5 got vec=%0d isr=%h want 5 20", vec, isr); else passed++;
    pulse_eoi();
    tick();
    pulse_inta();
    total++; if (vec !== 3'd0) $display("FAIL rot_grant0b got %0d want 0", vec); else passed++;
    rotate = 1'b0;
  endtask

  task automatic test_level();
    do_reset();
    ltim = 1'b1;
    irq = 8'h02; tick();
    total++; if (irr !== 8'h02) $display("FAIL lvl_irr got %h want 02", irr); else passed++;
    tick(); tick();
    total++; if (int_req !== 1'b1) $display("FAIL lvl_int got %0b want 1", int_req); else passed++;
    irq = 8'h00; tick(); tick();
    total++; if (irr !== 8'h00 || int_req !== 1'b0) $display("FAIL lvl_drop got irr=%h int=%0b want 00 0", irr, int_req); else passed++;
    pulse_inta();
    total++; if (isr !== 8'h00 || vec !== 3'd0) $display("FAIL lvl_spurious got isr=%h vec=%0d want 00 0", isr, vec); else passed++;
    ltim = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq = 8'h10; tick(); tick();
    pulse_inta();
    irq = 8'h31; tick();
    total++; if (isr !== 8'h10 || irr !== 8'h21) $display("FAIL mid_setup got isr=%h irr=%h want 10 21", isr, irr); else passed++;
    irq = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({int_req, vec, imr, irr, isr} !== '0) $display("FAIL mid_async got int=%0b vec=%0d imr=%h irr=%h isr=%h want all 0", int_req, vec, imr, irr, isr); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    irq = 8'h21; tick(); tick();
    pulse_inta();
    total++; if (vec !== 3'd0) $display("FAIL mid_lp_reset got %0d want 0", vec); else passed++;
  endtask

  initial begin
    test_reset();
    test_edge_grant();
    test_nested();
    test_mask();
    test_rotate();
    test_level();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
